// File: rtl/alu_seq_ctrl.sv
// Purpose: sequences one ALU command: read operand A, read operand B, launch ALU, wait, write result.
// Latency: command-to-done 7+k cycles (k = WAIT cycles until alu_done), 6+alu_timeout on timeout.
// Backpressure: cmd_ready only in IDLE; one command in flight, command inputs ignored while busy.
//
// Ports:
//   clk, rst (async, active-low)
//   cmd_valid/cmd_ready, cmd_op, cmd_src_a, cmd_src_b, cmd_dst : command handshake
//   mem_addr, mem_rd, mem_wr, mem_wdata, mem_rdata              : shared memory bus
//   alu_start, alu_op, alu_a, alu_b, alu_result, alu_done       : ALU launch/result
//   busy, done, err                                             : status (done/err are pulses)
module alu_seq_ctrl #(
    parameter int bus_width   = 8,
    parameter int addr_width  = 8,
    parameter int op_width    = 4,
    parameter int alu_timeout = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [op_width-1:0]   cmd_op,
    input  logic [addr_width-1:0] cmd_src_a,
    input  logic [addr_width-1:0] cmd_src_b,
    input  logic [addr_width-1:0] cmd_dst,
    output logic [addr_width-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [bus_width-1:0]  mem_wdata,
    input  logic [bus_width-1:0]  mem_rdata,
    output logic                  alu_start,
    output logic [op_width-1:0]   alu_op,
    output logic [bus_width-1:0]  alu_a,
    output logic [bus_width-1:0]  alu_b,
    input  logic [bus_width-1:0]  alu_result,
    input  logic                  alu_done,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [3:0] {
        st_idle,
        st_rd_a,
        st_lat_a,
        st_rd_b,
        st_lat_b,
        st_exec,
        st_wait,
        st_wr,
        st_done
    } state_t;

    // src_a is consumed at accept time (it goes straight onto mem_addr),
    // so only the fields needed later are held.
    typedef struct packed {
        logic [op_width-1:0]   op;
        logic [addr_width-1:0] src_b;
        logic [addr_width-1:0] dst;
    } cmd_t;

    // The counter holds (WAIT cycles elapsed - 1); hitting this value at the
    // end of a WAIT cycle means that cycle was WAIT number alu_timeout.
    localparam logic [7:0] cnt_last = 8'(alu_timeout - 1);

    state_t               state;
    cmd_t                 cmd_q;
    logic [bus_width-1:0] opa_q;
    logic [7:0]           cnt;

    // Every output is registered: each branch sets the values the outputs
    // must have in the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= st_idle;
            cmd_q     <= '0;
            opa_q     <= '0;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            alu_start <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
        end else begin
            // single-cycle strobes default low
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            alu_start <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                st_idle: begin
                    // also raises cmd_ready on the first edge after reset release
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_q.op    <= cmd_op;
                        cmd_q.src_b <= cmd_src_b;
                        cmd_q.dst   <= cmd_dst;
                        mem_addr    <= cmd_src_a;
                        mem_rd      <= 1'b1;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        state       <= st_rd_a;
                    end
                end
                st_rd_a: begin
                    state <= st_lat_a;
                end
                st_lat_a: begin
                    opa_q    <= mem_rdata;
                    mem_addr <= cmd_q.src_b;
                    mem_rd   <= 1'b1;
                    state    <= st_rd_b;
                end
                st_rd_b: begin
                    state <= st_lat_b;
                end
                st_lat_b: begin
                    // ALU inputs change only here, so they stay stable EXEC..WR
                    alu_op    <= cmd_q.op;
                    alu_a     <= opa_q;
                    alu_b     <= mem_rdata;
                    alu_start <= 1'b1;
                    state     <= st_exec;
                end
                st_exec: begin
                    cnt   <= '0;
                    state <= st_wait;
                end
                st_wait: begin
                    // alu_done wins over a simultaneous timeout
                    if (alu_done) begin
                        mem_wdata <= alu_result;
                        mem_addr  <= cmd_q.dst;
                        mem_wr    <= 1'b1;
                        state     <= st_wr;
                    end else if (cnt == cnt_last) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= st_done;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                st_wr: begin
                    done  <= 1'b1;
                    state <= st_done;
                end
                st_done: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= st_idle;
                end
                default: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b0;
                    state     <= st_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Purpose: randomized self-checking bench for alu_seq_ctrl with memory and ALU models.
// Latency: expectations derived from the command timeline (accept at cycle 0, done at 7+k).
// Backpressure: commands offered only in IDLE cycles, optionally with cmd_valid held high.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;

    localparam int tmo = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = '0;
    logic [7:0] cmd_src_a = '0;
    logic [7:0] cmd_src_b = '0;
    logic [7:0] cmd_dst = '0;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic       alu_start;
    logic [3:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result = '0;
    logic       alu_done = 1'b0;
    logic       busy;
    logic       done;
    logic       err;

    alu_seq_ctrl #(
        .bus_width  (8),
        .addr_width (8),
        .op_width   (4),
        .alu_timeout(tmo)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src_a (cmd_src_a),
        .cmd_src_b (cmd_src_b),
        .cmd_dst   (cmd_dst),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .alu_start (alu_start),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_result(alu_result),
        .alu_done  (alu_done),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // environment state
    logic [7:0] mem [256];
    int         cur_c   = -1;  // cycle index relative to accept, -1 outside commands
    int         done_at = -1;  // cycle in which the bench ALU answers
    int         spur_at = -1;  // cycle with a stray alu_done pulse
    logic       rd_pend = 1'b0;
    logic [7:0] rd_addr = '0;
    logic [3:0] seen_op = '0;
    logic [7:0] seen_a  = '0;
    logic [7:0] seen_b  = '0;
    int         wr_count = 0;
    logic [3:0] last_op = '0;
    logic [7:0] last_a  = '0;
    logic [7:0] last_b  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cur_c);
        end
    endtask

    // behaviour of the ALU attached in this bench
    function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // One clock: drive inputs just after the edge, observe at the falling edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        mem_rdata  = rd_pend ? mem[rd_addr] : 8'($urandom);
        rd_pend    = 1'b0;
        alu_done   = (cur_c == done_at) || (cur_c == spur_at);
        alu_result = (cur_c == done_at) ? ref_alu(seen_op, seen_a, seen_b) : 8'($urandom);
        @(negedge clk);
        if (mem_rd) begin
            rd_pend = 1'b1;
            rd_addr = mem_addr;
        end
        if (mem_wr) begin
            mem[mem_addr] = mem_wdata;
            wr_count++;
        end
        if (alu_start) begin
            seen_op = alu_op;
            seen_a  = alu_a;
            seen_b  = alu_b;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_done"},      32'(done), 0);
        check({tag, "_err"},       32'(err), 0);
        check({tag, "_mem_rd"},    32'(mem_rd), 0);
        check({tag, "_mem_wr"},    32'(mem_wr), 0);
        check({tag, "_alu_start"}, 32'(alu_start), 0);
        check({tag, "_mem_addr"},  32'(mem_addr), 0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_alu_op"},    32'(alu_op), 0);
        check({tag, "_alu_a"},     32'(alu_a), 0);
        check({tag, "_alu_b"},     32'(alu_b), 0);
    endtask

    // Called in an IDLE cycle (after its falling edge). k = WAIT cycle of
    // alu_done (0 = never). abort_c > 0 pulls reset after observing that cycle.
    task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] dst, input int k, input bit spur, input bit hold,
                           input int abort_c);
        logic [7:0] va, vb, vr, exp_addr;
        bit ok;
        int wr_c, done_c, wr0;
        va     = mem[a];
        vb     = mem[b];
        vr     = ref_alu(op, va, vb);
        ok     = (k >= 1) && (k <= tmo);
        wr_c   = ok ? 6 + k : -1;
        done_c = ok ? 7 + k : 6 + tmo;
        wr0    = wr_count;
        check("ready_c0", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_dst   = dst;
        done_at   = (k >= 1) ? 5 + k : -1;
        spur_at   = spur ? 1 : -1;
        for (int c = 1; c <= done_c + 1; c++) begin
            cur_c = c;
            cycle();
            if (c == 1) begin
                // junk on the command port while busy must be ignored
                cmd_valid = hold;
                cmd_op    = 4'($urandom);
                cmd_src_a = 8'($urandom);
                cmd_src_b = 8'($urandom);
                cmd_dst   = 8'($urandom);
            end
            if (c == abort_c) begin
                rst = 1'b0;
                #1;
                check_all_zero("rst_mid");
                cur_c   = -1;
                done_at = -1;
                spur_at = -1;
                cmd_valid = 1'b0;
                repeat (3) begin
                    cycle();
                    check("rst_hold_wr", 32'(mem_wr), 0);
                    check("rst_hold_ready", 32'(cmd_ready), 0);
                end
                rst = 1'b1;
                #1;
                check("ready_before_edge", 32'(cmd_ready), 0);
                cycle();
                check("ready_after_rst", 32'(cmd_ready), 1);
                check("busy_after_rst", 32'(busy), 0);
                check("rst_no_write", 32'(wr_count - wr0), 0);
                last_op = '0;
                last_a  = '0;
                last_b  = '0;
                return;
            end
            exp_addr = (c < 3) ? a : ((ok && c >= wr_c) ? dst : b);
            check("mem_rd",    32'(mem_rd), 32'(c == 1 || c == 3));
            check("mem_wr",    32'(mem_wr), 32'(c == wr_c));
            check("alu_start", 32'(alu_start), 32'(c == 5));
            check("done",      32'(done), 32'(c == done_c));
            check("err",       32'(err), 32'(c == done_c && !ok));
            check("busy",      32'(busy), 32'(c <= done_c));
            check("cmd_ready", 32'(cmd_ready), 32'(c > done_c));
            check("mem_addr",  32'(mem_addr), 32'(exp_addr));
            check("alu_op",    32'(alu_op), 32'((c < 5) ? last_op : op));
            check("alu_a",     32'(alu_a), 32'((c < 5) ? last_a : va));
            check("alu_b",     32'(alu_b), 32'((c < 5) ? last_b : vb));
            if (c == wr_c) check("mem_wdata", 32'(mem_wdata), 32'(vr));
        end
        check("write_count", 32'(wr_count - wr0), 32'(ok));
        if (ok) check("mem_dst", 32'(mem[dst]), 32'(vr));
        last_op = op;
        last_a  = va;
        last_b  = vb;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'h05;
        mem[8'h11] = 8'h03;

        // reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        #1;
        check("ready_pre_edge", 32'(cmd_ready), 0);
        cycle();
        check("ready_first_edge", 32'(cmd_ready), 1);

        // basic op, ALU answers in WAIT cycle 1
        run_cmd(4'd1, 8'h10, 8'h11, 8'h20, 1, 1'b0, 1'b0, -1);
        check("basic_result", 32'(mem[8'h20]), 32'h08);
        // slow ALU with a stray alu_done in RD_A
        run_cmd(4'd2, 8'h30, 8'h31, 8'h32, 4, 1'b1, 1'b0, -1);
        // timeout
        run_cmd(4'd3, 8'h40, 8'h41, 8'h42, 0, 1'b0, 1'b0, -1);
        // boundary: answer in the last WAIT cycle
        run_cmd(4'd4, 8'h50, 8'h51, 8'h52, tmo, 1'b0, 1'b0, -1);
        // back-to-back with cmd_valid held high
        run_cmd(4'd1, 8'h60, 8'h61, 8'h62, 2, 1'b0, 1'b1, -1);
        run_cmd(4'd5, 8'h62, 8'h60, 8'h63, 3, 1'b0, 1'b1, -1);
        run_cmd(4'd2, 8'h63, 8'h61, 8'h64, 1, 1'b0, 1'b0, -1);
        // aliased addresses
        run_cmd(4'd1, 8'h70, 8'h70, 8'h70, 2, 1'b0, 1'b0, -1);
        // reset in WAIT, then a normal command
        run_cmd(4'd1, 8'h80, 8'h81, 8'h82, 0, 1'b0, 1'b0, 8);
        run_cmd(4'd1, 8'h10, 8'h11, 8'h21, 1, 1'b0, 1'b0, -1);

        // randomized commands
        for (int n = 0; n < 30; n++) begin
            run_cmd(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, tmo)), 1'($urandom), (n < 29) ? 1'($urandom) : 1'b0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
